clk_div_multi: RTL and testbench

Parametrised multi-channel programmable clock divider, the successor to the fixed-divisor single-output divider. Each channel derives a divided clock-enable-style square wave from `clk_in`, with a runtime period and high time, a per-channel enable, and a one-cycle period-start tick. Divisor changes take effect only at a period boundary, so outputs never glitch. It sits beside the system clock source and feeds slow timing domains: sample strobes, LED/scan rates, and slow peripheral clocks.

---
 rtl/clk_div_multi.sv | 124 ++++++++++++
 tb/tb_clk_div_multi.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel period/high time with
// boundary-synchronous shadow updates. Optional `CLKDIV_SYNC_EN adds a sync input.
module clk_div_multi #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 32,
    parameter int DEFAULT_DIV  = 500,
    parameter int DEFAULT_HIGH = 250,
    parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync,
`endif
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic [CNT_W-1:0]    cfg_high,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_P   = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_H   = CNT_W'(DEFAULT_HIGH);

    logic [CNT_W-1:0] p_q   [CHANNELS];
    logic [CNT_W-1:0] p_d   [CHANNELS];
    logic [CNT_W-1:0] h_q   [CHANNELS];
    logic [CNT_W-1:0] h_d   [CHANNELS];
    logic [CNT_W-1:0] sp_q  [CHANNELS];
    logic [CNT_W-1:0] sp_d  [CHANNELS];
    logic [CNT_W-1:0] sh_q  [CHANNELS];
    logic [CNT_W-1:0] sh_d  [CHANNELS];
    logic [CNT_W-1:0] cnt_q [CHANNELS];
    logic [CNT_W-1:0] cnt_d [CHANNELS];

    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] clk_q, clk_d;
    logic                sync_s;

`ifdef CLKDIV_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // Out-of-range channel numbers match no channel, so they read as ready and are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CH_W'(i)) cfg_ready = !pending_q[i];
        end
    end

    always_comb begin
        p_d       = p_q;
        h_d       = h_q;
        sp_d      = sp_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        tick_d    = '0;
        clk_d     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // A parked channel (disabled or being synced) takes its shadow straight away.
            if (pending_q[i] && (!en[i] || sync_s || cnt_q[i] == p_q[i] - ONE)) begin
                p_d[i]       = sp_q[i];
                h_d[i]       = sh_q[i];
                pending_d[i] = 1'b0;
            end
            if (!en[i] || sync_s) begin
                cnt_d[i] = p_d[i] - ONE;
            end else if (cnt_q[i] == p_q[i] - ONE) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                clk_d[i]  = (h_d[i] != '0);
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
                clk_d[i] = (cnt_d[i] < h_q[i]);
            end
            // pending_q is clear whenever a write is accepted, so this never races an apply.
            if (cfg_valid && cfg_ready && cfg_chan == CH_W'(i)) begin
                sp_d[i]      = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
                sh_d[i]      = cfg_high;
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                p_q[i]   <= DEF_P;
                h_q[i]   <= DEF_H;
                sp_q[i]  <= DEF_P;
                sh_q[i]  <= DEF_H;
                cnt_q[i] <= DEF_P - ONE;
            end
            pending_q <= '0;
            tick_q    <= '0;
            clk_q     <= '0;
        end else begin
            p_q       <= p_d;
            h_q       <= h_d;
            sp_q      <= sp_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            clk_q     <= clk_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (4 channels, defaults 500/250).
module tb_clk_div_multi;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [3:0]  en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [31:0] cfg_div;
    logic [31:0] cfg_high;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  pending;
`ifdef CLKDIV_SYNC_EN
    logic        sync;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    clk_div_multi dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en),
`ifdef CLKDIV_SYNC_EN
        .sync     (sync),
`endif
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    always #5 clk_in = ~clk_in;

    // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = '0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0; cfg_high = '0;
`ifdef CLKDIV_SYNC_EN
        sync = 1'b0;
`endif
        step(); step();
        n_cmp++; if (clk_out !== 4'b0000) begin n_err++; $display("FAIL reset_clk_out: got %b expected 0000", clk_out); end
        n_cmp++; if (tick !== 4'b0000) begin n_err++; $display("FAIL reset_tick: got %b expected 0000", tick); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
        reset = 1'b0; en = 4'b1111; cyc = 0;
    endtask

    task automatic test_defaults();
        logic [3:0] exp_t, exp_c;
        int k;
        while (cyc < 1001) begin
            step();
            k = (cyc - 1) % 500;
            exp_t = {4{k == 0}};
            exp_c = {4{k < 250}};
            n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL def_tick cyc %0d: got %b expected %b", cyc, tick, exp_t); end
            n_cmp++; if (clk_out !== exp_c) begin n_err++; $display("FAIL def_clk cyc %0d: got %b expected %b", cyc, clk_out, exp_c); end
        end
    endtask

    task automatic test_cfg_update();
        logic [3:0] exp_t, exp_c, exp_p;
        int k;
        while (cyc < 1100) step();
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 32'd10; cfg_high = 32'd3;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL cfg1_ready: got %b expected 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (pending !== 4'b0010) begin n_err++; $display("FAIL cfg1_pending: got %b expected 0010", pending); end
        while (cyc < 1150) step();
        // Second write to ch1 must stall; ch2 and ch3 are free and take coerced values.
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 32'd99; cfg_high = 32'd99;
        #1;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready: got %b expected 0", cfg_ready); end
        cfg_chan = 2'd2; cfg_div = 32'd0; cfg_high = 32'd1;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL ch2_ready: got %b expected 1", cfg_ready); end
        step();
        cfg_chan = 2'd3; cfg_div = 32'd1; cfg_high = 32'd0;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL ch3_ready: got %b expected 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (pending !== 4'b1110) begin n_err++; $display("FAIL pend3: got %b expected 1110", pending); end
        while (cyc < 1500) step();
        n_cmp++; if (pending !== 4'b1110) begin n_err++; $display("FAIL pend_hold: got %b expected 1110", pending); end
        n_cmp++; if (tick !== 4'b0000) begin n_err++; $display("FAIL pre_wrap_tick: got %b expected 0000", tick); end
        step();
        n_cmp++; if (tick !== 4'b1111) begin n_err++; $display("FAIL wrap_tick: got %b expected 1111", tick); end
        n_cmp++; if (clk_out !== 4'b0111) begin n_err++; $display("FAIL wrap_clk: got %b expected 0111", clk_out); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL wrap_pending: got %b expected 0000", pending); end
        while (cyc < 1540) begin
            step();
            k = cyc - 1501;
            exp_t = {k % 2 == 0, k % 2 == 0, k % 10 == 0, 1'b0};
            exp_c = {1'b0, k % 2 == 0, k % 10 < 3, 1'b1};
            n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL new_tick cyc %0d: got %b expected %b", cyc, tick, exp_t); end
            n_cmp++; if (clk_out !== exp_c) begin n_err++; $display("FAIL new_clk cyc %0d: got %b expected %b", cyc, clk_out, exp_c); end
        end
        // Accepted on the very edge ch1 wraps: must wait for the following wrap.
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_div = 32'd10; cfg_high = 32'd12;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL h12_ready: got %b expected 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        k = cyc - 1501;
        while (cyc < 1580) begin
            k = cyc - 1501;
            exp_t = {k % 2 == 0, k % 2 == 0, k % 10 == 0, 1'b0};
            exp_c = {1'b0, k % 2 == 0, (cyc >= 1551) || (k % 10 < 3), 1'b1};
            exp_p = (cyc < 1551) ? 4'b0010 : 4'b0000;
            n_cmp++; if (tick !== exp_t) begin n_err++; $display("FAIL h12_tick cyc %0d: got %b expected %b", cyc, tick, exp_t); end
            n_cmp++; if (clk_out !== exp_c) begin n_err++; $display("FAIL h12_clk cyc %0d: got %b expected %b", cyc, clk_out, exp_c); end
            n_cmp++; if (pending !== exp_p) begin n_err++; $display("FAIL h12_pend cyc %0d: got %b expected %b", cyc, pending, exp_p); end
            step();
        end
    endtask

    task automatic test_enable();
        while (cyc < 1600) step();
        en = 4'b1110;
        step();
        n_cmp++; if (clk_out[0] !== 1'b0) begin n_err++; $display("FAIL dis_clk: got %b expected 0", clk_out[0]); end
        n_cmp++; if (tick[0] !== 1'b0) begin n_err++; $display("FAIL dis_tick: got %b expected 0", tick[0]); end
        while (cyc < 1603) step();
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 32'd6; cfg_high = 32'd2;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL dis_ready: got %b expected 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (pending[0] !== 1'b1) begin n_err++; $display("FAIL dis_pend_set: got %b expected 1", pending[0]); end
        step();
        n_cmp++; if (pending[0] !== 1'b0) begin n_err++; $display("FAIL dis_pend_clr: got %b expected 0", pending[0]); end
        while (cyc < 1610) step();
        en = 4'b1111;
        for (int j = 0; j < 20; j++) begin
            step();
            n_cmp++; if (tick[0] !== (j % 6 == 0)) begin n_err++; $display("FAIL reen_tick j %0d: got %b expected %b", j, tick[0], j % 6 == 0); end
            n_cmp++; if (clk_out[0] !== (j % 6 < 2)) begin n_err++; $display("FAIL reen_clk j %0d: got %b expected %b", j, clk_out[0], j % 6 < 2); end
        end
    endtask

    task automatic test_reset_mid();
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_div = 32'd20; cfg_high = 32'd5;
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (pending[2] !== 1'b1) begin n_err++; $display("FAIL mid_pend_pre: got %b expected 1", pending[2]); end
        n_cmp++; if (clk_out[1] !== 1'b1) begin n_err++; $display("FAIL mid_clk_pre: got %b expected 1", clk_out[1]); end
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (clk_out !== 4'b0000) begin n_err++; $display("FAIL mid_clk: got %b expected 0000", clk_out); end
        n_cmp++; if (tick !== 4'b0000) begin n_err++; $display("FAIL mid_tick: got %b expected 0000", tick); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL mid_pend: got %b expected 0000", pending); end
        step(); step();
        reset = 1'b0; en = 4'b1111; cyc = 0;
        step();
        n_cmp++; if (tick !== 4'b1111) begin n_err++; $display("FAIL rel_tick: got %b expected 1111", tick); end
        n_cmp++; if (clk_out !== 4'b1111) begin n_err++; $display("FAIL rel_clk: got %b expected 1111", clk_out); end
        while (cyc < 251) step();
        n_cmp++; if (clk_out !== 4'b0000) begin n_err++; $display("FAIL rel_low: got %b expected 0000", clk_out); end
        while (cyc < 501) step();
        n_cmp++; if (tick !== 4'b1111) begin n_err++; $display("FAIL rel_tick501: got %b expected 1111", tick); end
    endtask

`ifdef CLKDIV_SYNC_EN
    task automatic test_sync();
        en = 4'b0000;
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 32'd7; cfg_high = 32'd3;
        step();
        cfg_chan = 2'd1; cfg_div = 32'd5; cfg_high = 32'd2;
        step();
        cfg_valid = 1'b0;
        step();
        en = 4'b0001;
        step(); step(); step();
        en = 4'b0011;
        for (int j = 0; j < 6; j++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        n_cmp++; if (tick !== 4'b0000) begin n_err++; $display("FAIL sync_tick0: got %b expected 0000", tick); end
        n_cmp++; if (clk_out !== 4'b0000) begin n_err++; $display("FAIL sync_clk0: got %b expected 0000", clk_out); end
        step();
        n_cmp++; if (tick !== 4'b0011) begin n_err++; $display("FAIL sync_tick1: got %b expected 0011", tick); end
        n_cmp++; if (clk_out !== 4'b0011) begin n_err++; $display("FAIL sync_clk1: got %b expected 0011", clk_out); end
        for (int j = 1; j <= 10; j++) begin
            step();
            n_cmp++; if (tick[1:0] !== {j % 5 == 0, j % 7 == 0}) begin n_err++; $display("FAIL sync_run j %0d: got %b expected %b", j, tick[1:0], {j % 5 == 0, j % 7 == 0}); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_defaults();
        test_cfg_update();
        test_enable();
        test_reset_mid();
`ifdef CLKDIV_SYNC_EN
        test_sync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
